// File: rtl/spu_regfile_sb_if.sv
// rtl/spu_regfile_sb_if.sv - write/read/scoreboard/clear bundle for the SPU register file
interface spu_regfile_sb_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 7,
   parameter int NUM_RD = 6,
   parameter int NUM_WR = 2
);
   logic                       clr_req;
   logic                       clr_busy;
   logic [NUM_WR-1:0]          wr_en;
   logic [NUM_WR*ADDR_W-1:0]   wr_addr;
   logic [NUM_WR*DATA_W-1:0]   wr_data;
   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD*DATA_W-1:0]   rd_data;
   logic                       sb_set_en;
   logic [ADDR_W-1:0]          sb_set_addr;
   logic [NUM_RD-1:0]          rd_pending;

   modport master (
      output clr_req, wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
      input  clr_busy, rd_data, rd_pending
   );

   modport slave (
      input  clr_req, wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
      output clr_busy, rd_data, rd_pending
   );
endinterface

// File: rtl/spu_regfile_sb.sv
// rtl/spu_regfile_sb.sv - multi-port register file with pending scoreboard and zero sweep
module spu_regfile_sb #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 7,
   parameter int NUM_RD = 6,
   parameter int NUM_WR = 2
) (
   input  logic           clk,
   input  logic           rst,
   spu_regfile_sb_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DEPTH-1:0]    sb_q, sb_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic [ADDR_W-1:0]   wa [NUM_WR];
   logic [DATA_W-1:0]   wd [NUM_WR];
   logic [ADDR_W-1:0]   ra [NUM_RD];
   logic [NUM_WR-1:0]   we;
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]   rd_pend_c;

   for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
      assign wa[k] = bus.wr_addr[k*ADDR_W +: ADDR_W];
      assign wd[k] = bus.wr_data[k*DATA_W +: DATA_W];
   end

   for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      assign ra[j] = bus.rd_addr[j*ADDR_W +: ADDR_W];
   end

   // Writes only take effect while idle; the sweep owns the array otherwise.
   assign we = bus.wr_en & {NUM_WR{state_q == IDLE}};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sb_d    = sb_q;
      case (state_q)
         IDLE: begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (we[k]) sb_d[wa[k]] = 1'b0;
            end
            if (bus.sb_set_en) sb_d[bus.sb_set_addr] = 1'b1;
            if (bus.clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
               sb_d    = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == LAST) state_d = IDLE;
            else               cnt_d   = cnt_q + ADDR_W'(1);
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         sb_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sb_q    <= sb_d;
      end
   end

   // No per-entry reset: the sweep is the only zeroing path. Later ports overwrite earlier ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
         end else begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (we[k]) mem_q[wa[k]] <= wd[k];
            end
         end
      end
   end

   always_comb begin
      rd_data_c = '0;
      rd_pend_c = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         rd_data_c[j*DATA_W +: DATA_W] = mem_q[ra[j]];
         rd_pend_c[j] = sb_q[ra[j]];
         for (int k = 0; k < NUM_WR; k++) begin
            if (we[k] && (wa[k] == ra[j])) begin
               rd_data_c[j*DATA_W +: DATA_W] = wd[k];
               if (!(bus.sb_set_en && (bus.sb_set_addr == ra[j]))) rd_pend_c[j] = 1'b0;
            end
         end
         if (state_q == CLEAR) begin
            rd_data_c[j*DATA_W +: DATA_W] = '0;
            rd_pend_c[j] = 1'b0;
         end
      end
   end

   assign bus.rd_data    = rd_data_c;
   assign bus.rd_pending = rd_pend_c;
   assign bus.clr_busy   = (state_q == CLEAR);
endmodule
